// File: rtl/vdc_pkg.sv
// vdc_pkg: shared types and constants for the VDC CPU-side register interface.
// Holds the register file type, register index constants and the readback mask table.
// Also holds the bus-interface FSM state enum and a helper that classifies live registers.
package vdc_pkg;

  localparam int         VDC_NREGS   = 37;
  localparam logic [4:0] VDC_VERSION = 5'd2;

  // Register indices with special handling
  localparam logic [5:0] VDC_R_UA_HI = 6'd18;
  localparam logic [5:0] VDC_R_UA_LO = 6'd19;
  localparam logic [5:0] VDC_R_COPY  = 6'd24;
  localparam logic [5:0] VDC_R_RAM   = 6'd28;
  localparam logic [5:0] VDC_R_WC    = 6'd30;
  localparam logic [5:0] VDC_R_DA    = 6'd31;
  localparam logic [5:0] VDC_R_BA_HI = 6'd32;
  localparam logic [5:0] VDC_R_BA_LO = 6'd33;

  typedef logic [0:VDC_NREGS-1][7:0] regfile_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } bState_t;

  // Bits set here are unimplemented and read back as 1
  function automatic logic [7:0] vdc_rd_mask(input logic [5:0] idx);
    logic [7:0] m;
    m = 8'h00;
    case (idx)
      6'd5, 6'd9, 6'd11, 6'd23, 6'd29: m = 8'hE0;
      6'd8:                            m = 8'hFC;
      6'd10:                           m = 8'h80;
      6'd28:                           m = 8'h3F;
      6'd36:                           m = 8'hF0;
      default:                         m = 8'h00;
    endcase
    return m;
  endfunction

  // Registers whose value lives in vdc_ramiface rather than in the local file
  function automatic logic vdc_is_live(input logic [5:0] idx);
    return (idx == VDC_R_UA_HI) || (idx == VDC_R_UA_LO) ||
           (idx == VDC_R_WC)    || (idx == VDC_R_DA)    ||
           (idx == VDC_R_BA_HI) || (idx == VDC_R_BA_LO);
  endfunction

endpackage

// File: rtl/vdc_busiface.sv
// vdc_busiface: $D600/$D601 decode, address register, 37-entry register file, status/readback, strobes to vdc_ramiface.
// Latency: local writes and readback land in the access enable cycle; a forwarded access strobes ri_* one enable cycle later.
// Backpressure: CPU is never stalled; forwarded access while busy is dropped, or held in a one-entry last-write-wins slot when VDC_WRBUF_EN is defined.
module vdc_busiface
  import vdc_pkg::*;
#(
  parameter logic [4:0] VERSION = VDC_VERSION,
  parameter int         NREGS   = VDC_NREGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  enableBus,
  input  logic                  cs,
  input  logic                  rs,
  input  logic                  we,
  input  logic [7:0]            db_in,
  output logic [7:0]            db_out,
  input  logic                  lp_flag,
  input  logic                  vblank,
  input  logic                  ram_busy,
  input  logic [15:0]           reg_ua,
  input  logic [7:0]            reg_wc,
  input  logic [7:0]            reg_da,
  input  logic [15:0]           reg_ba,
  output logic                  ri_enableBus,
  output logic                  ri_cs,
  output logic                  ri_rs,
  output logic                  ri_we,
  output logic [7:0]            ri_regA,
  output logic [7:0]            ri_db,
  output logic                  reg_copy,
  output logic                  reg_ram,
  output logic [0:NREGS-1][7:0] regs
);

  // State
  logic [7:0]            regA_q, regA_d;
  logic [0:NREGS-1][7:0] regs_q, regs_d;
  logic [7:0]            db_out_q, db_out_d;
  logic                  live_rd_q, live_rd_d;
  logic [5:0]            trk_idx_q, trk_idx_d;
  bState_t               state_q, state_d;
  logic                  ri_enableBus_q, ri_enableBus_d;
  logic                  ri_cs_q, ri_cs_d;
  logic                  ri_rs_q, ri_rs_d;
  logic                  ri_we_q, ri_we_d;
  logic [7:0]            ri_regA_q, ri_regA_d;
  logic [7:0]            ri_db_q, ri_db_d;
  logic                  pend_valid;

`ifdef VDC_WRBUF_EN
  logic                  pend_valid_q, pend_valid_d;
  logic [7:0]            pend_regA_q, pend_regA_d;
  logic [7:0]            pend_db_q, pend_db_d;
  logic                  pend_we_q, pend_we_d;
  assign pend_valid = pend_valid_q;
`else
  assign pend_valid = 1'b0;
`endif

  // Access decode
  logic       acc, st_wr, st_rd, dp_wr, dp_rd;
  logic [5:0] idx;
  logic       reg_impl, idx_live, fwd_acc, busy_any;
  logic [7:0] status, rd_val, trk_val;

  assign acc      = enable & enableBus & cs;
  assign st_wr    = acc & ~rs & we;
  assign st_rd    = acc & ~rs & ~we;
  assign dp_wr    = acc & rs & we;
  assign dp_rd    = acc & rs & ~we;
  assign idx      = regA_q[5:0];
  assign reg_impl = (regA_q < 8'(NREGS));
  assign idx_live = vdc_is_live(idx);
  // Writes to live registers and reads of R31 (READNEXT) go to vdc_ramiface
  assign fwd_acc  = reg_impl & ((dp_wr & idx_live) | (dp_rd & (idx == VDC_R_DA)));
  assign busy_any = ram_busy | (state_q != S_IDLE) | pend_valid;
  assign status   = {~busy_any, lp_flag, vblank, VERSION};

  function automatic logic [7:0] live_val(input logic [5:0] i, input logic [15:0] ua,
                                          input logic [7:0] wc, input logic [7:0] da,
                                          input logic [15:0] ba);
    logic [7:0] v;
    v = 8'h00;
    case (i)
      VDC_R_UA_HI: v = ua[15:8];
      VDC_R_UA_LO: v = ua[7:0];
      VDC_R_WC:    v = wc;
      VDC_R_DA:    v = da;
      VDC_R_BA_HI: v = ba[15:8];
      VDC_R_BA_LO: v = ba[7:0];
      default:     v = 8'h00;
    endcase
    return v;
  endfunction

  // Readback mux for the addressed register and for the live register db_out is tracking
  always_comb begin
    rd_val = 8'hFF;
    if (reg_impl) begin
      if (idx_live) rd_val = live_val(idx, reg_ua, reg_wc, reg_da, reg_ba) | vdc_rd_mask(idx);
      else          rd_val = regs_q[idx] | vdc_rd_mask(idx);
    end
    trk_val = live_val(trk_idx_q, reg_ua, reg_wc, reg_da, reg_ba) | vdc_rd_mask(trk_idx_q);
  end

  // Next state: address register, local register file, CPU read data and forwarding FSM
  always_comb begin
    regA_d         = regA_q;
    regs_d         = regs_q;
    db_out_d       = db_out_q;
    live_rd_d      = live_rd_q;
    trk_idx_d      = trk_idx_q;
    state_d        = state_q;
    ri_enableBus_d = ri_enableBus_q;
    ri_cs_d        = ri_cs_q;
    ri_rs_d        = ri_rs_q;
    ri_we_d        = ri_we_q;
    ri_regA_d      = ri_regA_q;
    ri_db_d        = ri_db_q;

    if (st_wr) regA_d = {2'b00, db_in[5:0]};

    // Live registers keep no local copy except WC/DA, which the display side reads
    if (dp_wr && reg_impl && (!idx_live || idx == VDC_R_WC || idx == VDC_R_DA))
      regs_d[idx] = db_in;

    if (dp_rd) begin
      db_out_d  = rd_val;
      live_rd_d = reg_impl & idx_live;
      trk_idx_d = idx;
    end else if (st_rd) begin
      db_out_d  = status;
      live_rd_d = 1'b0;
    end else if (live_rd_q) begin
      db_out_d  = trk_val;
    end

    case (state_q)
      S_IDLE: begin
`ifdef VDC_WRBUF_EN
        if (pend_valid_q) begin
          ri_regA_d      = pend_regA_q;
          ri_db_d        = pend_db_q;
          ri_we_d        = pend_we_q;
          ri_enableBus_d = 1'b1;
          ri_cs_d        = 1'b1;
          ri_rs_d        = 1'b1;
          state_d        = S_ISSUE;
        end else
`endif
        if (fwd_acc) begin
          ri_regA_d      = regA_q;
          ri_db_d        = db_in;
          ri_we_d        = we;
          ri_enableBus_d = 1'b1;
          ri_cs_d        = 1'b1;
          ri_rs_d        = 1'b1;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ri_enableBus_d = 1'b0;
        ri_cs_d        = 1'b0;
        ri_rs_d        = 1'b0;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        if (!ram_busy) state_d = S_IDLE;
      end
      default: begin
        ri_enableBus_d = 1'b0;
        ri_cs_d        = 1'b0;
        ri_rs_d        = 1'b0;
        state_d        = S_IDLE;
      end
    endcase
  end

`ifdef VDC_WRBUF_EN
  // Holding slot: drained when the FSM is idle, refilled by any forwarded access it cannot take now
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_regA_d  = pend_regA_q;
    pend_db_d    = pend_db_q;
    pend_we_d    = pend_we_q;
    if (state_q == S_IDLE && pend_valid_q) pend_valid_d = 1'b0;
    if (fwd_acc && (state_q != S_IDLE || pend_valid_q)) begin
      pend_valid_d = 1'b1;
      pend_regA_d  = regA_q;
      pend_db_d    = db_in;
      pend_we_d    = we;
    end
  end
`endif

  // Registers advance on enable; reset clears everything including any in-flight strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      regA_q         <= '0;
      regs_q         <= '0;
      db_out_q       <= '0;
      live_rd_q      <= 1'b0;
      trk_idx_q      <= '0;
      state_q        <= S_IDLE;
      ri_enableBus_q <= 1'b0;
      ri_cs_q        <= 1'b0;
      ri_rs_q        <= 1'b0;
      ri_we_q        <= 1'b0;
      ri_regA_q      <= '0;
      ri_db_q        <= '0;
`ifdef VDC_WRBUF_EN
      pend_valid_q   <= 1'b0;
      pend_regA_q    <= '0;
      pend_db_q      <= '0;
      pend_we_q      <= 1'b0;
`endif
    end else if (enable) begin
      regA_q         <= regA_d;
      regs_q         <= regs_d;
      db_out_q       <= db_out_d;
      live_rd_q      <= live_rd_d;
      trk_idx_q      <= trk_idx_d;
      state_q        <= state_d;
      ri_enableBus_q <= ri_enableBus_d;
      ri_cs_q        <= ri_cs_d;
      ri_rs_q        <= ri_rs_d;
      ri_we_q        <= ri_we_d;
      ri_regA_q      <= ri_regA_d;
      ri_db_q        <= ri_db_d;
`ifdef VDC_WRBUF_EN
      pend_valid_q   <= pend_valid_d;
      pend_regA_q    <= pend_regA_d;
      pend_db_q      <= pend_db_d;
      pend_we_q      <= pend_we_d;
`endif
    end
  end

  assign db_out       = db_out_q;
  assign ri_enableBus = ri_enableBus_q;
  assign ri_cs        = ri_cs_q;
  assign ri_rs        = ri_rs_q;
  assign ri_we        = ri_we_q;
  assign ri_regA      = ri_regA_q;
  assign ri_db        = ri_db_q;
  assign regs         = regs_q;
  assign reg_copy     = regs_q[VDC_R_COPY][7];
  assign reg_ram      = regs_q[VDC_R_RAM][4];

endmodule

// File: tb/tb_vdc_busiface.sv
// tb_vdc_busiface: directed scenarios plus randomized CPU traffic against a register-level model.
// A small ramiface responder records every strobe and answers with a configurable busy time.
// Recorded strobes and readback values are compared with what the model says the CPU asked for.
module tb_vdc_busiface;
  import vdc_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable, enableBus, cs, rs, we;
  logic [7:0]  db_in, db_out;
  logic        lp_flag, vblank;
  logic        ram_busy = 1'b0;
  logic [15:0] reg_ua, reg_ba;
  logic [7:0]  reg_wc, reg_da;
  logic        ri_enableBus, ri_cs, ri_rs, ri_we;
  logic [7:0]  ri_regA, ri_db;
  logic        reg_copy, reg_ram;
  regfile_t    regs;

  always #5 clk = ~clk;

  vdc_busiface dut (
    .clk(clk), .reset(reset), .enable(enable), .enableBus(enableBus), .cs(cs), .rs(rs), .we(we),
    .db_in(db_in), .db_out(db_out), .lp_flag(lp_flag), .vblank(vblank), .ram_busy(ram_busy),
    .reg_ua(reg_ua), .reg_wc(reg_wc), .reg_da(reg_da), .reg_ba(reg_ba),
    .ri_enableBus(ri_enableBus), .ri_cs(ri_cs), .ri_rs(ri_rs), .ri_we(ri_we),
    .ri_regA(ri_regA), .ri_db(ri_db), .reg_copy(reg_copy), .reg_ram(reg_ram), .regs(regs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  ref_regs [37];
  int          ref_regA;
  logic [16:0] exp_q [$];   // {we, regA, db} the CPU asked to forward
  logic [16:0] obs_q [$];   // strobes seen by the responder

  function automatic logic [7:0] tb_mask(input int i);
    case (i)
      5, 9, 11, 23, 29: return 8'hE0;
      8:                return 8'hFC;
      10:               return 8'h80;
      28:               return 8'h3F;
      36:               return 8'hF0;
      default:          return 8'h00;
    endcase
  endfunction

  function automatic bit tb_live(input int i);
    return (i == 18) || (i == 19) || (i == 30) || (i == 31) || (i == 32) || (i == 33);
  endfunction

  function automatic logic [7:0] tb_live_val(input int i);
    case (i)
      18:      return reg_ua[15:8];
      19:      return reg_ua[7:0];
      30:      return reg_wc;
      31:      return reg_da;
      32:      return reg_ba[15:8];
      default: return reg_ba[7:0];
    endcase
  endfunction

  // ramiface responder: records each strobe and holds busy for busy_len cycles
  int busy_len   = 3;
  bit busy_clear = 1'b0;
  int busy_cnt   = 0;
  always @(negedge clk) begin
    if (ri_enableBus) begin
      obs_q.push_back({ri_we, ri_regA, ri_db});
      check("strobe_cs_rs", {30'd0, ri_cs, ri_rs}, 32'd3);
    end
    if (busy_clear)        busy_cnt = 0;
    else if (ri_enableBus) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    ram_busy = (busy_cnt > 0);
  end

  task automatic cpu(input logic r, input logic w, input logic [7:0] d);
    rs = r; we = w; db_in = d; enableBus = 1'b1; cs = 1'b1;
    @(posedge clk); #1;
    enableBus = 1'b0; cs = 1'b0; we = 1'b0; db_in = 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      cpu(1'b0, 1'b0, 8'h00);
      if (db_out[7]) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_cmp(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_strobe"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 37; i++) ref_regs[i] = 8'h00;
    ref_regA = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, e;
    logic       rb;
    int         op, ra;

    reset = 1'b1; enable = 1'b1; enableBus = 1'b0; cs = 1'b0; rs = 1'b0; we = 1'b0;
    db_in = 8'h00; lp_flag = 1'b0; vblank = 1'b0;
    reg_ua = 16'h1234; reg_wc = 8'h07; reg_da = 8'h5A; reg_ba = 16'hBEEF;
    model_reset();
    tick(3);
    check("rst_db_out", db_out, 8'h00);
    check("rst_ri", {ri_enableBus, ri_cs, ri_rs, ri_we, ri_regA, ri_db}, 20'h0);
    check("rst_regs_hi", regs[0:18], '0);
    check("rst_regs_lo", regs[19:36], '0);
    reset = 1'b0;

    // Status after reset, then R0
    cpu(1'b0, 1'b0, 8'h00);
    check("t1_status", db_out, 8'h82);
    cpu(1'b0, 1'b1, 8'h00);
    cpu(1'b1, 1'b0, 8'h00);
    check("t1_r0", db_out, 8'h00);

    // Local register R28 with readback mask, no forwarding
    cpu(1'b0, 1'b1, 8'h1C);
    cpu(1'b1, 1'b1, 8'h10);
    ref_regs[28] = 8'h10;
    check("t2_reg_ram", reg_ram, 1'b1);
    cpu(1'b1, 1'b0, 8'h00);
    check("t2_readback", db_out, 8'h3F);
    tick(4);
    check("t2_no_strobe", obs_q.size(), 0);

    // Forwarded write to R18
    busy_len = 4;
    cpu(1'b0, 1'b1, 8'd18);
    cpu(1'b1, 1'b1, 8'h12);
    exp_q.push_back({1'b1, 8'd18, 8'h12});
    cpu(1'b0, 1'b0, 8'h00);
    check("t3_busy_issue", db_out[7], 1'b0);
    tick(1);
    cpu(1'b0, 1'b0, 8'h00);
    check("t3_busy_wait", db_out[7], 1'b0);
    wait_idle();
    drain_cmp("t3");

    // R31 read forwards a read strobe and db_out follows reg_da
    cpu(1'b0, 1'b1, 8'd31);
    cpu(1'b1, 1'b0, 8'h00);
    exp_q.push_back({1'b0, 8'd31, 8'h00});
    check("t4_da", db_out, 8'h5A);
    reg_da = 8'hC3;
    tick(1);
    check("t4_da_track", db_out, 8'hC3);
    wait_idle();
    drain_cmp("t4");

    // Back-to-back forwarded writes while busy
    busy_len = 6;
    cpu(1'b0, 1'b1, 8'd30);
    cpu(1'b1, 1'b1, 8'h50);
    exp_q.push_back({1'b1, 8'd30, 8'h50});
    cpu(1'b0, 1'b1, 8'd31);
    cpu(1'b1, 1'b1, 8'hAA);
`ifdef VDC_WRBUF_EN
    exp_q.push_back({1'b1, 8'd31, 8'hAA});
`endif
    ref_regs[30] = 8'h50;
    ref_regs[31] = 8'hAA;
    wait_idle();
    tick(3);
    drain_cmp("t5");
    check("t5_r30_local", regs[30], 8'h50);
    check("t5_r31_local", regs[31], 8'hAA);

    // Reset in the middle of a transfer, with a second access queued behind it
    busy_len = 20;
    cpu(1'b0, 1'b1, 8'd19);
    cpu(1'b1, 1'b1, 8'h77);
    exp_q.push_back({1'b1, 8'd19, 8'h77});
    cpu(1'b1, 1'b1, 8'h88);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_reset();
    check("t6_ri_clear", {ri_enableBus, ri_cs, ri_rs, ri_we, ri_regA, ri_db}, 20'h0);
    cpu(1'b0, 1'b0, 8'h00);
    check("t6_busy_held", db_out[7], 1'b0);
    busy_clear = 1'b1;
    tick(1);
    busy_clear = 1'b0;
    tick(1);
    cpu(1'b0, 1'b0, 8'h00);
    check("t6_status", db_out, 8'h82);
    tick(8);
    drain_cmp("t6");

    // Randomized CPU traffic
    for (int n = 0; n < 300; n++) begin
      reg_ua = 16'($urandom); reg_wc = 8'($urandom); reg_da = 8'($urandom); reg_ba = 16'($urandom);
      lp_flag = 1'($urandom); vblank = 1'($urandom);
      busy_len = $urandom_range(1, 5);
      op = $urandom_range(0, 5);
      ra = ref_regA;
      d  = 8'($urandom);
      case (op)
        0: begin
          d[5:0] = 6'($urandom_range(0, 45));
          cpu(1'b0, 1'b1, d);
          ref_regA = int'(d[5:0]);
        end
        1, 2: begin
          if (ra < 37 && tb_live(ra)) begin
            wait_idle();
            exp_q.push_back({1'b1, 8'(ra), d});
          end
          cpu(1'b1, 1'b1, d);
          if (ra < 37 && (!tb_live(ra) || ra == 30 || ra == 31)) ref_regs[ra] = d;
        end
        3, 4: begin
          if (ra == 31) begin
            wait_idle();
            exp_q.push_back({1'b0, 8'd31, 8'h00});
          end
          if (ra >= 37)        e = 8'hFF;
          else if (tb_live(ra)) e = tb_live_val(ra) | tb_mask(ra);
          else                 e = ref_regs[ra] | tb_mask(ra);
          cpu(1'b1, 1'b0, 8'h00);
          check("rnd_read", db_out, e);
          if (ra < 37 && tb_live(ra)) begin
            reg_ua = 16'($urandom); reg_wc = 8'($urandom); reg_da = 8'($urandom); reg_ba = 16'($urandom);
            tick(1);
            check("rnd_track", db_out, tb_live_val(ra) | tb_mask(ra));
          end
        end
        default: begin
          @(negedge clk);
          rb = ram_busy;
          cpu(1'b0, 1'b0, 8'h00);
          check("rnd_status", db_out[6:0], {lp_flag, vblank, 5'd2});
          if (rb) check("rnd_status_busy", db_out[7], 1'b0);
        end
      endcase
    end
    wait_idle();
    tick(3);
    drain_cmp("rnd");
    for (int i = 0; i < 37; i++) check("rnd_regfile", regs[i], ref_regs[i]);
    check("rnd_reg_copy", reg_copy, ref_regs[24][7]);
    check("rnd_reg_ram", reg_ram, ref_regs[28][4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
